// File: rtl/spi_cmd_slave.sv
// SPI mode-0 slave command engine. CSn/SCLK/MOSI are oversampled in i_clk and the
// command byte plus 32-bit word stream drive IMEM writes, IMEM reads or status readout.
module spi_cmd_slave #(
    parameter int         AW       = 12,
    parameter logic [7:0] CMD_ECHO = 8'h5A
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_CSn,
    input  logic          i_SCLK,
    input  logic          i_MOSI,
    output logic          o_MISO,
    output logic          o_mem_cyc,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_adr,
    output logic [31:0]   o_mem_dat,
    input  logic [31:0]   i_mem_rdt,
    input  logic          i_mem_ack,
    input  logic [31:0]   i_status,
    output logic          o_prog_done,
    output logic          o_err,
    output logic          o_busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WORD, ST_DRAIN} state_t;
    typedef enum logic [1:0] {MD_STATUS, MD_READ, MD_WRITE} mode_t;

    logic [1:0]    csn_q;
    logic [2:0]    sclk_q;
    logic [1:0]    mosi_q;
    state_t        state_q, state_d;
    mode_t         mode_q, mode_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [7:0]    rx_sr_q, rx_sr_d;
    logic [23:0]   word_q, word_d;
    logic [7:0]    tx_sr_q, tx_sr_d;
    logic [31:0]   tx_word_q, tx_word_d;
    logic [AW-1:0] wr_adr_q, wr_adr_d;
    logic          rd_pend_q, rd_pend_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          csn_s, sclk_rise, sclk_fall;
    logic [7:0]    rx_byte, tx_byte;
    logic [31:0]   rx_word;

    assign csn_s     = csn_q[1];
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign rx_byte   = {rx_sr_q[6:0], mosi_q[1]};
    assign rx_word   = {rx_byte, word_q};

    // Words go out LSB byte first; byte_cnt_q already points at the next byte to send.
    always_comb begin
        unique case (byte_cnt_q)
            2'd0:    tx_byte = tx_word_q[7:0];
            2'd1:    tx_byte = tx_word_q[15:8];
            2'd2:    tx_byte = tx_word_q[23:16];
            default: tx_byte = tx_word_q[31:24];
        endcase
    end

    always_comb begin
        // NOTE: every _d starts as its _q so no branch below can leave one unassigned (no latches).
        state_d    = state_q;
        mode_d     = mode_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        rx_sr_d    = rx_sr_q;
        word_d     = word_q;
        tx_sr_d    = tx_sr_q;
        tx_word_d  = tx_word_q;
        wr_adr_d   = wr_adr_q;
        rd_pend_d  = rd_pend_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        done_d     = 1'b0;
        err_d      = err_q;

        // Memory handshake runs independently of CSn so an aborted session still completes it.
        if (cyc_q && i_mem_ack) begin
            cyc_d = 1'b0;
            if (rd_pend_q) begin
                tx_word_d = i_mem_rdt;
                rd_pend_d = 1'b0;
            end
        end

        if (csn_s) begin
            state_d = ST_IDLE;
            tx_sr_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d    = ST_CMD;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    wr_adr_d   = '0;
                    rd_pend_d  = 1'b0;
                    tx_sr_d    = CMD_ECHO;
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        rx_sr_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_cnt_d = '0;
                            tx_word_d  = '0;
                            state_d    = ST_WORD;
                            unique case (rx_byte)
                                8'h00: begin
                                    mode_d    = MD_STATUS;
                                    tx_word_d = i_status;
                                end
                                8'h01:   mode_d  = MD_READ;
                                8'h02:   mode_d  = MD_WRITE;
                                default: state_d = ST_DRAIN;
                            endcase
                        end
                    end else if (sclk_fall) begin
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    end
                end
                ST_WORD: begin
                    if (sclk_rise) begin
                        rx_sr_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                            unique case (byte_cnt_q)
                                2'd0: word_d[7:0]   = rx_byte;
                                2'd1: word_d[15:8]  = rx_byte;
                                2'd2: word_d[23:16] = rx_byte;
                                default: begin
                                    unique case (mode_q)
                                        MD_WRITE: begin
                                            tx_word_d = rx_word;
                                            if (rx_word == 32'hFFFF_FFFF) begin
                                                done_d  = 1'b1;
                                                state_d = ST_DRAIN;
                                            end else if (cyc_q) begin
                                                err_d = 1'b1;
                                            end else begin
                                                cyc_d    = 1'b1;
                                                we_d     = 1'b1;
                                                adr_d    = wr_adr_q;
                                                dat_d    = rx_word;
                                                wr_adr_d = wr_adr_q + AW'(4);
                                            end
                                        end
                                        MD_READ: begin
                                            if (cyc_q) begin
                                                err_d = 1'b1;
                                            end else begin
                                                cyc_d     = 1'b1;
                                                we_d      = 1'b0;
                                                adr_d     = rx_word[AW-1:0];
                                                rd_pend_d = 1'b1;
                                            end
                                        end
                                        default: tx_word_d = i_status;
                                    endcase
                                end
                            endcase
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt_q != 3'd0) begin
                            tx_sr_d = {tx_sr_q[6:0], 1'b0};
                        end else if (byte_cnt_q == 2'd0 && mode_q == MD_READ && rd_pend_q) begin
                            // Read data missed its slot: return all-ones and ignore the late ack.
                            tx_word_d = 32'hFFFF_FFFF;
                            tx_sr_d   = 8'hFF;
                            rd_pend_d = 1'b0;
                            err_d     = 1'b1;
                        end else begin
                            tx_sr_d = tx_byte;
                        end
                    end
                end
                default: begin
                    if (sclk_fall) begin
                        tx_sr_d = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            csn_q      <= 2'b11;
            sclk_q     <= '0;
            mosi_q     <= '0;
            state_q    <= ST_IDLE;
            mode_q     <= MD_STATUS;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            rx_sr_q    <= '0;
            word_q     <= '0;
            tx_sr_q    <= '0;
            tx_word_q  <= '0;
            wr_adr_q   <= '0;
            rd_pend_q  <= 1'b0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            csn_q      <= {csn_q[0], i_CSn};
            sclk_q     <= {sclk_q[1:0], i_SCLK};
            mosi_q     <= {mosi_q[0], i_MOSI};
            state_q    <= state_d;
            mode_q     <= mode_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            rx_sr_q    <= rx_sr_d;
            word_q     <= word_d;
            tx_sr_q    <= tx_sr_d;
            tx_word_q  <= tx_word_d;
            wr_adr_q   <= wr_adr_d;
            rd_pend_q  <= rd_pend_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign o_MISO      = tx_sr_q[7];
    assign o_mem_cyc   = cyc_q;
    assign o_mem_we    = we_q;
    assign o_mem_adr   = adr_q;
    assign o_mem_dat   = dat_q;
    assign o_prog_done = done_q;
    assign o_err       = err_q;
    assign o_busy      = ~csn_s;

endmodule
